alu_op_sequencer: RTL

//   Command front-end sitting directly upstream of TotalALU. Accepts {funct, A, B} commands on a

---
 rtl/alu_op_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Command front-end for TotalALU: issues one command at a time, waits out MULTU,
// auto-collects Hi/Lo via MFHI/MFLO and returns one response per command.
module alu_op_sequencer #(
  parameter int ALU_LAT    = 1,
  parameter int MUL_CYCLES = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_funct,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_data_a,
  output logic [31:0] alu_data_b,
  output logic        alu_binvert,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_hi,
  output logic        rsp_err,
  output logic        busy
);

  // Handshake rule (both channels): a transfer happens on a rising edge where
  // valid and ready are both high; the producer holds its payload stable until then.

  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(ALU_LAT - 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  typedef enum logic [2:0] {
    IDLE, EXEC, MUL_WAIT, RD_HI, RD_LO, RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  function automatic logic is_single(input logic [5:0] f);
    return (f == F_AND) || (f == F_OR) || (f == F_ADD) ||
           (f == F_SUB) || (f == F_SLT) || (f == F_SRL);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_hi      <= '0;
      rsp_err     <= 1'b0;
      alu_signal  <= '0;
      alu_data_a  <= '0;
      alu_data_b  <= '0;
      alu_binvert <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
            if (is_single(cmd_funct) || cmd_funct == F_MULTU) begin
              alu_signal  <= cmd_funct;
              alu_data_a  <= cmd_a;
              alu_data_b  <= cmd_b;
              alu_binvert <= (cmd_funct == F_SUB) || (cmd_funct == F_SLT);
              state       <= (cmd_funct == F_MULTU) ? MUL_WAIT : EXEC;
            end else begin
              // Unsupported funct: answer straight away, leave the ALU untouched.
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_hi    <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt == LAT_LAST) begin
            rsp_data  <= alu_result;
            rsp_hi    <= '0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MUL_WAIT: begin
          if (cnt == MUL_LAST) begin
            alu_signal <= F_MFHI;
            cnt        <= '0;
            state      <= RD_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_HI: begin
          if (cnt == LAT_LAST) begin
            rsp_hi     <= alu_result;
            alu_signal <= F_MFLO;
            cnt        <= '0;
            state      <= RD_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_LO: begin
          if (cnt == LAT_LAST) begin
            rsp_data  <= alu_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // Going to IDLE here means the earliest next accept is one edge later.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
